mc_ctrl_hs: RTL and testbench
=============================

Name: mc_ctrl_hs

Overview:
- Next-generation multi-cycle MIPS control FSM for the mccpu datapath.
- Adds variable-latency memory via a `mem_ready` handshake, jr/jalr/bne, illegal-opcode trap with EPC capture, parametrised ALUOp width, and a retired-instruction counter.
- Sits between the IR opcode/funct fields and the datapath muxes/enables, replacing the fixed-latency controller.

Parameters:
- ALUOP_W, 4, width of ALUOp (≥4).
- MEM_HS, 1, 1 = honour `mem_ready`; 0 = `mem_ready` internally tied to 1.
- TRAP_EN, 1, 1 = illegal opcode enters TRAP; 0 = illegal opcode retires as NOP.
- CNT_W, 32, width of `instret`.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- Zero  in  1  ALU zero flag.
- Op  in  6  opcode.
- Funct  in  6  R-type funct.
- mem_ready  in  1  memory completes current access this cycle.
- RegWrite, MemWrite, MemRead, PCWrite, IRWrite, EPCWrite  out  1 each  write/read enables.
- EXTOp  out  1  1 = sign extend, 0 = zero extend.
- ALUOp  out  ALUOP_W  operation, ALU_* encoding from package.
- ALUSrcA  out  2  0 PC, 1 ReadData1, 2 shamt.
- ALUSrcB  out  2  0 ReadData2, 1 const 4, 2 ext imm, 3 branch offset.
- PCSource  out  3  0 ALU, 1 ALUOut, 2 jump target, 3 ReadData1, 4 trap vector.
- GPRSel  out  2  0 rd, 1 rt, 2 r31.
- WDSel  out  2  0 ALU, 1 MEM, 2 PC.
- IorD  out  1  0 instruction address, 1 ALUOut.
- trap  out  1  one-cycle pulse on trap entry.
- state_o  out  3  current state, for debug.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Registered state and `instret`; all other outputs are combinational from state, Op, Funct, Zero and `mem_ready`.
- Reset (rst=0, async): state=IF, instret=0.
  - While rst=0, all enables (RegWrite, MemWrite, MemRead, PCWrite, IRWrite, EPCWrite) and `trap` are forced 0.
  - Defaults apply otherwise: EXTOp=1, ALUSrcA=1, ALUSrcB=0, ALUOp=ADD, PCSource=0, GPRSel=0, WDSel=0, IorD=0.
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4, TRAP=5; codes 6/7 go to IF.
- IF:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1.
  - PCWrite=IRWrite=`mem_ready`.
  - Stay in IF until `mem_ready`=1, then go to ID.
- ID:
  - j: PCSource=2, PCWrite → IF.
  - jal: same as j, plus RegWrite, GPRSel=2, WDSel=2 → IF.
  - jr: PCSource=3, PCWrite → IF.
  - jalr: same as jr, plus RegWrite, GPRSel=0, WDSel=2 → IF.
  - Illegal opcode/funct with TRAP_EN=1 → TRAP; with TRAP_EN=0 → IF, no writes.
  - Otherwise: ALUSrcA=0, ALUSrcB=3 (branch target into ALUOut) → EXE.
- EXE, ALUOp decode:
  - add/addu/addi/lw/sw = ADD; sub/subu/beq/bne = SUB; and/andi = AND; or/ori = OR.
  - slt/slti = SLT; sltu = SLTU; sll/sllv = SLL; srl/srlv = SRL; nor = NOR; lui = LUI.
- EXE, actions:
  - beq/bne: PCSource=1, PCWrite = (beq&Zero)|(bne&~Zero) → IF.
  - lw/sw: ALUSrcB=2 → MEM.
  - sll/srl: ALUSrcA=2 → WB.
  - addi/slti/andi/ori/lui: ALUSrcB=2, EXTOp=0 for andi/ori/lui → WB.
  - Other R-type → WB.
- MEM:
  - IorD=1; MemRead=lw; MemWrite=sw.
  - Hold in MEM until `mem_ready`=1.
  - Then lw → WB, sw → IF.
  - Enables stay asserted and stable every wait cycle.
- WB:
  - RegWrite=1; WDSel=1 for lw.
  - GPRSel=1 for lw and all I-type ALU ops.
  - → IF.
- TRAP: EPCWrite=1, PCWrite=1, PCSource=4, trap=1 → IF.
- `instret`:
  - Increments by 1 on every transition into IF from ID/EXE/MEM/WB, including not-taken branches and TRAP_EN=0 NOPs.
  - Does not increment from TRAP.
  - Wraps modulo 2^CNT_W.
- Reset asserted mid-access: state returns to IF immediately and the memory request drops in the same cycle.

Decomposition:
- Package `mc_ctrl_pkg`:
  - State codes.
  - ALU_* codes: NOP 0, ADD 1, SUB 2, AND 3, OR 4, SLT 5, SLTU 6, SLL 7, NOR 8, LUI 9, SRL 10.
  - PCSRC_*, GPRSEL_*, WDSEL_* and ALUSRCA/B_* constants.
  - Opcode/funct constants.
- Sub-module `mc_decode`: purely combinational Op/Funct → one-hot instruction flags plus an `illegal` flag.

Test Plan:
- addu with mem_ready stuck 0 for 3 cycles in IF: IRWrite/PCWrite low for 3 cycles, one pulse on the 4th; full sequence IF×4, ID, EXE, WB; instret 0→1.
- lw with 2 wait cycles in MEM: MemRead=1 and IorD=1 for 3 consecutive cycles; WB then has RegWrite=1, WDSel=1, GPRSel=1.
- bne with Zero=0 → PCWrite=1, PCSource=1 in EXE; repeat with Zero=1 → PCWrite=0; instret +1 in both cases.
- jalr (Op=0, Funct=6'h09): ID has PCWrite=1, PCSource=3, RegWrite=1, WDSel=2, GPRSel=0; next state IF.
- Op=6'h3F with TRAP_EN=1: ID→TRAP; trap=1, EPCWrite=1, PCSource=4 for one cycle; instret unchanged. With TRAP_EN=0: ID→IF with no enables asserted; instret +1.
- rst pulled low during a MEM wait: state_o=0 and MemRead=0 in the same cycle; after rst=1, fetch restarts with instret=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants and types for the multi-cycle MIPS controller.
//   - FSM state codes (3-bit, also exported on state_o)
//   - ALU_* operation codes (4-bit, zero-extended to ALUOP_W at the top)
//   - datapath mux select constants (PCSRC_*, GPRSEL_*, WDSEL_*, ALUSRCA/B_*)
//   - opcode / funct constants and the decoded instruction flag struct
package mc_ctrl_pkg;

    // FSM states
    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EXE  = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_TRAP = 3'd5;

    // ALU operations
    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_NOR  = 4'd8;
    localparam logic [3:0] ALU_LUI  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;

    // Datapath mux selects
    localparam logic [2:0] PCSRC_ALU    = 3'd0;
    localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_RS     = 3'd3;
    localparam logic [2:0] PCSRC_TRAP   = 3'd4;

    localparam logic [1:0] GPRSEL_RD  = 2'd0;
    localparam logic [1:0] GPRSEL_RT  = 2'd1;
    localparam logic [1:0] GPRSEL_R31 = 2'd2;

    localparam logic [1:0] WDSEL_ALU = 2'd0;
    localparam logic [1:0] WDSEL_MEM = 2'd1;
    localparam logic [1:0] WDSEL_PC  = 2'd2;

    localparam logic [1:0] ALUSRCA_PC    = 2'd0;
    localparam logic [1:0] ALUSRCA_RS    = 2'd1;
    localparam logic [1:0] ALUSRCA_SHAMT = 2'd2;

    localparam logic [1:0] ALUSRCB_RT   = 2'd0;
    localparam logic [1:0] ALUSRCB_FOUR = 2'd1;
    localparam logic [1:0] ALUSRCB_IMM  = 2'd2;
    localparam logic [1:0] ALUSRCB_BOFF = 2'd3;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // One-hot instruction flags; exactly one bit set for any Op/Funct pair.
    typedef struct packed {
        logic add_r, addu_r, sub_r, subu_r, and_r, or_r, nor_r, slt_r, sltu_r;
        logic sll_r, srl_r, sllv_r, srlv_r, jr_r, jalr_r;
        logic j, jal, beq, bne, addi, slti, andi, ori, lui, lw, sw;
        logic illegal;
    } inst_t;

    // ALU operation used in EXE for a decoded instruction.
    function automatic logic [3:0] alu_sel(input inst_t d);
        logic [3:0] a;
        a = ALU_ADD;
        if (d.sub_r | d.subu_r | d.beq | d.bne)       a = ALU_SUB;
        else if (d.and_r | d.andi)                    a = ALU_AND;
        else if (d.or_r | d.ori)                      a = ALU_OR;
        else if (d.slt_r | d.slti)                    a = ALU_SLT;
        else if (d.sltu_r)                            a = ALU_SLTU;
        else if (d.sll_r | d.sllv_r)                  a = ALU_SLL;
        else if (d.srl_r | d.srlv_r)                  a = ALU_SRL;
        else if (d.nor_r)                             a = ALU_NOR;
        else if (d.lui)                               a = ALU_LUI;
        return a;
    endfunction

endpackage

// File: rtl/mc_ctrl_hs_decode.sv
// mc_decode: combinational instruction decoder.
//   op, funct : instruction opcode / R-type funct fields
//   dec       : one-hot instruction flags; dec.illegal for any unsupported pair
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output inst_t      dec
);

    always_comb begin
        dec = '0;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD:  dec.add_r  = 1'b1;
                FN_ADDU: dec.addu_r = 1'b1;
                FN_SUB:  dec.sub_r  = 1'b1;
                FN_SUBU: dec.subu_r = 1'b1;
                FN_AND:  dec.and_r  = 1'b1;
                FN_OR:   dec.or_r   = 1'b1;
                FN_NOR:  dec.nor_r  = 1'b1;
                FN_SLT:  dec.slt_r  = 1'b1;
                FN_SLTU: dec.sltu_r = 1'b1;
                FN_SLL:  dec.sll_r  = 1'b1;
                FN_SRL:  dec.srl_r  = 1'b1;
                FN_SLLV: dec.sllv_r = 1'b1;
                FN_SRLV: dec.srlv_r = 1'b1;
                FN_JR:   dec.jr_r   = 1'b1;
                FN_JALR: dec.jalr_r = 1'b1;
                default: dec.illegal = 1'b1;
            endcase
        end else begin
            case (op)
                OP_J:    dec.j    = 1'b1;
                OP_JAL:  dec.jal  = 1'b1;
                OP_BEQ:  dec.beq  = 1'b1;
                OP_BNE:  dec.bne  = 1'b1;
                OP_ADDI: dec.addi = 1'b1;
                OP_SLTI: dec.slti = 1'b1;
                OP_ANDI: dec.andi = 1'b1;
                OP_ORI:  dec.ori  = 1'b1;
                OP_LUI:  dec.lui  = 1'b1;
                OP_LW:   dec.lw   = 1'b1;
                OP_SW:   dec.sw   = 1'b1;
                default: dec.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multi-cycle MIPS control FSM with memory handshake.
//   clk, rst (async, active low), Zero, Op, Funct, mem_ready : inputs
//   RegWrite/MemWrite/MemRead/PCWrite/IRWrite/EPCWrite     : enables
//   EXTOp, ALUOp, ALUSrcA/B, PCSource, GPRSel, WDSel, IorD  : datapath selects
//   trap    : one-cycle pulse in TRAP state
//   state_o : current FSM state
//   instret : retired-instruction counter (wraps)
module mc_ctrl_hs
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int MEM_HS  = 1,
    parameter int TRAP_EN = 1,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Zero,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               EPCWrite,
    output logic               EXTOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         PCSource,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               IorD,
    output logic               trap,
    output logic [2:0]         state_o,
    output logic [CNT_W-1:0]   instret
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    inst_t            dec;
    logic             rdy, retire, itype_alu;

    // Raw (ungated) control values
    logic       reg_wr, mem_wr, mem_rd, pc_wr, ir_wr, epc_wr, trap_p;
    logic       ext_op, iord;
    logic [3:0] alu_code;
    logic [1:0] src_a, src_b, gpr_sel, wd_sel;
    logic [2:0] pc_src;

    mc_decode u_dec (
        .op    (Op),
        .funct (Funct),
        .dec   (dec)
    );

    assign rdy       = (MEM_HS != 0) ? mem_ready : 1'b1;
    assign itype_alu = dec.addi | dec.slti | dec.andi | dec.ori | dec.lui;

    always_comb begin
        state_d  = S_IF;
        reg_wr   = 1'b0;
        mem_wr   = 1'b0;
        mem_rd   = 1'b0;
        pc_wr    = 1'b0;
        ir_wr    = 1'b0;
        epc_wr   = 1'b0;
        trap_p   = 1'b0;
        ext_op   = 1'b1;
        alu_code = ALU_ADD;
        src_a    = ALUSRCA_RS;
        src_b    = ALUSRCB_RT;
        pc_src   = PCSRC_ALU;
        gpr_sel  = GPRSEL_RD;
        wd_sel   = WDSEL_ALU;
        iord     = 1'b0;
        case (state_q)
            S_IF: begin
                // PC+4 computed every cycle; only committed when the fetch completes.
                mem_rd  = 1'b1;
                src_a   = ALUSRCA_PC;
                src_b   = ALUSRCB_FOUR;
                pc_wr   = rdy;
                ir_wr   = rdy;
                state_d = rdy ? S_ID : S_IF;
            end
            S_ID: begin
                if (dec.j | dec.jal) begin
                    pc_src = PCSRC_JUMP;
                    pc_wr  = 1'b1;
                    if (dec.jal) begin
                        reg_wr  = 1'b1;
                        gpr_sel = GPRSEL_R31;
                        wd_sel  = WDSEL_PC;
                    end
                    state_d = S_IF;
                end else if (dec.jr_r | dec.jalr_r) begin
                    pc_src = PCSRC_RS;
                    pc_wr  = 1'b1;
                    if (dec.jalr_r) begin
                        reg_wr  = 1'b1;
                        gpr_sel = GPRSEL_RD;
                        wd_sel  = WDSEL_PC;
                    end
                    state_d = S_IF;
                end else if (dec.illegal) begin
                    state_d = (TRAP_EN != 0) ? S_TRAP : S_IF;
                end else begin
                    // Precompute branch target into ALUOut.
                    src_a   = ALUSRCA_PC;
                    src_b   = ALUSRCB_BOFF;
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                alu_code = alu_sel(dec);
                if (dec.beq | dec.bne) begin
                    pc_src  = PCSRC_ALUOUT;
                    pc_wr   = (dec.beq & Zero) | (dec.bne & ~Zero);
                    state_d = S_IF;
                end else if (dec.lw | dec.sw) begin
                    src_b   = ALUSRCB_IMM;
                    state_d = S_MEM;
                end else if (dec.sll_r | dec.srl_r) begin
                    src_a   = ALUSRCA_SHAMT;
                    state_d = S_WB;
                end else if (itype_alu) begin
                    src_b   = ALUSRCB_IMM;
                    ext_op  = ~(dec.andi | dec.ori | dec.lui);
                    state_d = S_WB;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // Request held steady until the memory acknowledges.
                iord   = 1'b1;
                mem_rd = dec.lw;
                mem_wr = dec.sw;
                if (!rdy)        state_d = S_MEM;
                else if (dec.lw) state_d = S_WB;
                else             state_d = S_IF;
            end
            S_WB: begin
                reg_wr  = 1'b1;
                wd_sel  = dec.lw ? WDSEL_MEM : WDSEL_ALU;
                gpr_sel = (dec.lw | itype_alu) ? GPRSEL_RT : GPRSEL_RD;
                state_d = S_IF;
            end
            S_TRAP: begin
                epc_wr  = 1'b1;
                pc_wr   = 1'b1;
                pc_src  = PCSRC_TRAP;
                trap_p  = 1'b1;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // Only completed instructions count; TRAP exit and stray codes 6/7 do not.
    assign retire = (state_d == S_IF) &&
                    ((state_q == S_ID) || (state_q == S_EXE) ||
                     (state_q == S_MEM) || (state_q == S_WB));

    always_comb begin
        instret_d = instret_q;
        if (retire) instret_d = instret_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IF;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Enables are gated by rst directly so a mid-access reset drops the
    // memory request combinationally, not on the next edge.
    assign RegWrite = rst & reg_wr;
    assign MemWrite = rst & mem_wr;
    assign MemRead  = rst & mem_rd;
    assign PCWrite  = rst & pc_wr;
    assign IRWrite  = rst & ir_wr;
    assign EPCWrite = rst & epc_wr;
    assign trap     = rst & trap_p;

    assign EXTOp    = ext_op;
    assign ALUOp    = ALUOP_W'(alu_code);
    assign ALUSrcA  = src_a;
    assign ALUSrcB  = src_b;
    assign PCSource = pc_src;
    assign GPRSel   = gpr_sel;
    assign WDSel    = wd_sel;
    assign IorD     = iord;
    assign state_o  = state_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Bench for mc_ctrl_hs. Two instances: dut_a (defaults) and dut_b
// (TRAP_EN=0, MEM_HS=0, CNT_W=3, ALUOP_W=5); one is held in reset while
// the other is exercised. The reference walks each instruction through its
// phase list and builds the expected control word from the instruction class.
module tb_mc_ctrl_hs;

    typedef struct packed {
        logic       regw, memw, memr, pcw, irw, epcw, extop;
        logic [7:0] aluop;
        logic [1:0] srca, srcb;
        logic [2:0] pcsrc;
        logic [1:0] gpr, wd;
        logic       iord, trap;
        logic [2:0] st;
    } ctl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, rst_b = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] op = '0, funct = '0;
    logic       tsel = 1'b0;

    logic a_regw, a_memw, a_memr, a_pcw, a_irw, a_epcw, a_extop, a_iord, a_trap;
    logic [3:0] a_aluop;
    logic [1:0] a_srca, a_srcb, a_gpr, a_wd;
    logic [2:0] a_pcsrc, a_st;
    logic [31:0] a_cnt;

    logic b_regw, b_memw, b_memr, b_pcw, b_irw, b_epcw, b_extop, b_iord, b_trap;
    logic [4:0] b_aluop;
    logic [1:0] b_srca, b_srcb, b_gpr, b_wd;
    logic [2:0] b_pcsrc, b_st;
    logic [2:0] b_cnt;

    mc_ctrl_hs dut_a (
        .clk(clk), .rst(rst_a), .Zero(zero), .Op(op), .Funct(funct), .mem_ready(mem_ready),
        .RegWrite(a_regw), .MemWrite(a_memw), .MemRead(a_memr), .PCWrite(a_pcw),
        .IRWrite(a_irw), .EPCWrite(a_epcw), .EXTOp(a_extop), .ALUOp(a_aluop),
        .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .PCSource(a_pcsrc), .GPRSel(a_gpr),
        .WDSel(a_wd), .IorD(a_iord), .trap(a_trap), .state_o(a_st), .instret(a_cnt)
    );

    mc_ctrl_hs #(.ALUOP_W(5), .MEM_HS(0), .TRAP_EN(0), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst_b), .Zero(zero), .Op(op), .Funct(funct), .mem_ready(mem_ready),
        .RegWrite(b_regw), .MemWrite(b_memw), .MemRead(b_memr), .PCWrite(b_pcw),
        .IRWrite(b_irw), .EPCWrite(b_epcw), .EXTOp(b_extop), .ALUOp(b_aluop),
        .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .PCSource(b_pcsrc), .GPRSel(b_gpr),
        .WDSel(b_wd), .IorD(b_iord), .trap(b_trap), .state_o(b_st), .instret(b_cnt)
    );

    ctl_t obs_a, obs_b, obs;
    logic [31:0] cnt_obs;
    assign obs_a = {a_regw, a_memw, a_memr, a_pcw, a_irw, a_epcw, a_extop, 4'b0, a_aluop,
                    a_srca, a_srcb, a_pcsrc, a_gpr, a_wd, a_iord, a_trap, a_st};
    assign obs_b = {b_regw, b_memw, b_memr, b_pcw, b_irw, b_epcw, b_extop, 3'b0, b_aluop,
                    b_srca, b_srcb, b_pcsrc, b_gpr, b_wd, b_iord, b_trap, b_st};
    assign obs     = tsel ? obs_b : obs_a;
    assign cnt_obs = tsel ? {29'd0, b_cnt} : a_cnt;

    int          n_vec = 0, n_err = 0;
    logic [31:0] icount = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit legal(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00)
            return f inside {6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h09, 6'h20, 6'h21,
                             6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B};
        return o inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                         6'h0F, 6'h23, 6'h2B};
    endfunction

    // ALU codes: NOP0 ADD1 SUB2 AND3 OR4 SLT5 SLTU6 SLL7 NOR8 LUI9 SRL10
    function automatic logic [7:0] alu_of(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) begin
            case (f)
                6'h22, 6'h23: return 8'd2;
                6'h24:        return 8'd3;
                6'h25:        return 8'd4;
                6'h2A:        return 8'd5;
                6'h2B:        return 8'd6;
                6'h00, 6'h04: return 8'd7;
                6'h27:        return 8'd8;
                6'h02, 6'h06: return 8'd10;
                default:      return 8'd1;
            endcase
        end
        case (o)
            6'h04, 6'h05: return 8'd2;
            6'h0C:        return 8'd3;
            6'h0D:        return 8'd4;
            6'h0A:        return 8'd5;
            6'h0F:        return 8'd9;
            default:      return 8'd1;
        endcase
    endfunction

    function automatic ctl_t base(input logic [2:0] st);
        ctl_t c;
        c = '0; c.extop = 1'b1; c.srca = 2'd1; c.aluop = 8'd1; c.st = st;
        return c;
    endfunction

    function automatic ctl_t if_word(input bit rdy);
        ctl_t c;
        c = base(3'd0); c.memr = 1'b1; c.srca = 2'd0; c.srcb = 2'd1;
        c.pcw = rdy; c.irw = rdy;
        return c;
    endfunction

    function automatic ctl_t id_word(input logic [5:0] o, input logic [5:0] f);
        ctl_t c;
        c = base(3'd1);
        if (o == 6'h02 || o == 6'h03) begin
            c.pcsrc = 3'd2; c.pcw = 1'b1;
            if (o == 6'h03) begin c.regw = 1'b1; c.gpr = 2'd2; c.wd = 2'd2; end
        end else if (o == 6'h00 && (f == 6'h08 || f == 6'h09)) begin
            c.pcsrc = 3'd3; c.pcw = 1'b1;
            if (f == 6'h09) begin c.regw = 1'b1; c.gpr = 2'd0; c.wd = 2'd2; end
        end else if (legal(o, f)) begin
            c.srca = 2'd0; c.srcb = 2'd3;
        end
        return c;
    endfunction

    function automatic ctl_t exe_word(input logic [5:0] o, input logic [5:0] f, input logic z);
        ctl_t c;
        c = base(3'd2); c.aluop = alu_of(o, f);
        if (o == 6'h04 || o == 6'h05) begin
            c.pcsrc = 3'd1; c.pcw = (o == 6'h04) ? z : ~z;
        end else if (o == 6'h23 || o == 6'h2B) c.srcb = 2'd2;
        else if (o == 6'h00 && (f == 6'h00 || f == 6'h02)) c.srca = 2'd2;
        else if (o != 6'h00) begin
            c.srcb = 2'd2; c.extop = !(o == 6'h0C || o == 6'h0D || o == 6'h0F);
        end
        return c;
    endfunction

    function automatic ctl_t mem_word(input logic [5:0] o);
        ctl_t c;
        c = base(3'd3); c.iord = 1'b1; c.memr = (o == 6'h23); c.memw = (o == 6'h2B);
        return c;
    endfunction

    function automatic ctl_t wb_word(input logic [5:0] o);
        ctl_t c;
        c = base(3'd4); c.regw = 1'b1;
        c.wd = (o == 6'h23) ? 2'd1 : 2'd0; c.gpr = (o != 6'h00) ? 2'd1 : 2'd0;
        return c;
    endfunction

    function automatic ctl_t trap_word();
        ctl_t c;
        c = base(3'd5); c.epcw = 1'b1; c.pcw = 1'b1; c.pcsrc = 3'd4; c.trap = 1'b1;
        return c;
    endfunction

    function automatic ctl_t rst_word();
        ctl_t c;
        c = if_word(1'b0); c.memr = 1'b0;
        return c;
    endfunction

    task automatic bump();
        icount = (icount + 1) & (tsel ? 32'h7 : 32'hFFFF_FFFF);
    endtask

    task automatic step(input ctl_t e, input string tag);
        @(negedge clk);
        chk({tag, "_ctl"}, 64'(obs), 64'(e));
        chk({tag, "_cnt"}, 64'(cnt_obs), 64'(icount));
        @(posedge clk); #1;
    endtask

    // One instruction from fetch to retirement. rst_mem >= 0 asserts dut_a
    // reset during that MEM wait cycle and abandons the instruction.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int iw, input int mw, input int rst_mem);
        bit hs, rdy, jmp;
        hs = (tsel == 1'b0);
        op = o; funct = f; zero = z;
        for (int c = 0; c <= iw; c++) begin
            rdy = hs ? (c == iw) : 1'b1;
            mem_ready = hs ? rdy : 1'($urandom);
            step(if_word(rdy), "if");
            if (rdy) break;
        end
        mem_ready = 1'($urandom);
        jmp = (o == 6'h02) || (o == 6'h03) || (o == 6'h00 && (f == 6'h08 || f == 6'h09));
        step(id_word(o, f), "id");
        if (jmp) begin bump(); return; end
        if (!legal(o, f)) begin
            if (hs) step(trap_word(), "trap");
            else    bump();
            return;
        end
        mem_ready = 1'($urandom);
        step(exe_word(o, f, z), "exe");
        if (o == 6'h04 || o == 6'h05) begin bump(); return; end
        if (o == 6'h23 || o == 6'h2B) begin
            for (int c = 0; c <= mw; c++) begin
                rdy = hs ? (c == mw) : 1'b1;
                mem_ready = hs ? rdy : 1'($urandom);
                if (c == rst_mem) begin
                    @(negedge clk);
                    chk("mem_pre_rst", 64'(obs), 64'(mem_word(o)));
                    #2 rst_a = 1'b0;
                    #1 icount = 0;
                    chk("rst_mid_ctl", 64'(obs), 64'(rst_word()));
                    chk("rst_mid_cnt", 64'(cnt_obs), 64'(icount));
                    @(posedge clk); #1 mem_ready = 1'b1;
                    @(negedge clk);
                    chk("rst_hold", 64'(obs), 64'(rst_word()));
                    @(posedge clk); #1 rst_a = 1'b1;
                    return;
                end
                step(mem_word(o), "mem");
                if (rdy) break;
            end
            if (o == 6'h2B) begin bump(); return; end
        end
        mem_ready = 1'($urandom);
        step(wb_word(o), "wb");
        bump();
    endtask

    localparam int NI = 27;
    logic [11:0] itab [0:NI-1];

    task automatic random_run(input int n);
        logic [11:0] pick;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(7) == 0) pick = 12'($urandom);
            else                        pick = itab[$urandom_range(NI - 1)];
            run_instr(pick[11:6], pick[5:0], 1'($urandom), $urandom_range(3),
                      $urandom_range(3), -1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        itab = '{ {6'h00, 6'h20}, {6'h00, 6'h21}, {6'h00, 6'h22}, {6'h00, 6'h23},
                  {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h27}, {6'h00, 6'h2A},
                  {6'h00, 6'h2B}, {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h04},
                  {6'h00, 6'h06}, {6'h00, 6'h08}, {6'h00, 6'h09}, {6'h02, 6'h00},
                  {6'h03, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h08, 6'h00},
                  {6'h0A, 6'h00}, {6'h0C, 6'h00}, {6'h0D, 6'h00}, {6'h0F, 6'h00},
                  {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h3F, 6'h3F} };

        // Reset state on both instances, with mem_ready high to show gating.
        op = 6'h23; mem_ready = 1'b1;
        #2 rst_a = 1'b0; rst_b = 1'b0;
        #2 chk("reset_a", 64'(obs), 64'(rst_word()));
        chk("reset_a_cnt", 64'(cnt_obs), 64'(icount));
        tsel = 1'b1;
        #1 chk("reset_b", 64'(obs), 64'(rst_word()));
        chk("reset_b_cnt", 64'(cnt_obs), 64'(icount));
        tsel = 1'b0;
        @(posedge clk); #1 rst_a = 1'b1;

        // Directed cases on dut_a (handshake on, trap on).
        run_instr(6'h00, 6'h21, 1'b0, 3, 0, -1);   // addu, 3 fetch waits
        run_instr(6'h23, 6'h00, 1'b0, 0, 2, -1);   // lw, 2 MEM waits
        run_instr(6'h05, 6'h00, 1'b0, 0, 0, -1);   // bne taken
        run_instr(6'h05, 6'h00, 1'b1, 1, 0, -1);   // bne not taken
        run_instr(6'h00, 6'h09, 1'b0, 0, 0, -1);   // jalr
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0, -1);   // illegal -> TRAP
        run_instr(6'h2B, 6'h00, 1'b0, 0, 1, -1);   // sw, 1 MEM wait
        run_instr(6'h0D, 6'h00, 1'b0, 0, 0, -1);   // ori, zero-extend
        run_instr(6'h23, 6'h00, 1'b0, 0, 3, 1);    // reset during MEM wait
        run_instr(6'h00, 6'h20, 1'b0, 0, 0, -1);   // restart after reset
        random_run(150);

        // dut_b: no handshake, illegal retires as NOP, 3-bit counter wraps.
        rst_a = 1'b0;
        tsel = 1'b1; icount = 0;
        @(posedge clk); #1 rst_b = 1'b1;
        run_instr(6'h3F, 6'h3F, 1'b0, 2, 0, -1);
        run_instr(6'h23, 6'h00, 1'b0, 2, 2, -1);
        run_instr(6'h00, 6'h02, 1'b0, 0, 0, -1);
        random_run(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
